// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the two-master pipelined Wishbone arbiter:
//   state_t      - arbiter FSM state (IDLE, GRANT0, GRANT1)
//   C_ADDR_SIZE  - default Wishbone address width
//   C_DATA_SIZE  - default Wishbone data width
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int C_ADDR_SIZE = 8;
    localparam int C_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// One pipelined-Wishbone link (classic cyc/stb/we/addr/data request channel
// plus stall/ack/data response channel).
//   master modport : drives cyc, stb, we, addr, wdata; receives stall, ack, rdata
//   slave modport  : receives cyc, stb, we, addr, wdata; drives stall, ack, rdata
// -----------------------------------------------------------------------------
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int G_ADDR_SIZE = C_ADDR_SIZE,
    parameter int G_DATA_SIZE = C_DATA_SIZE
) ();

    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [G_ADDR_SIZE-1:0] addr;
    logic [G_DATA_SIZE-1:0] wdata;
    logic                   stall;
    logic                   ack;
    logic [G_DATA_SIZE-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata,
        input  stall, ack, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata,
        output stall, ack, rdata
    );

endinterface

// File: rtl/wb_arbiter_grant.sv
// -----------------------------------------------------------------------------
// wb_arbiter_grant
// Grant decision for the two-master arbiter: registered FSM state and the
// last_grant history bit.
//   clk   in  : clock, rising edge
//   rst   in  : synchronous active-high reset (state IDLE, last_grant 1)
//   cyc0  in  : master 0 cycle request
//   cyc1  in  : master 1 cycle request
//   state out : current arbiter state
// Build option: WB_ARBITER_ROUND_ROBIN_EN - ties go to the master that did not
// win last time; otherwise ties always go to master 0.
// -----------------------------------------------------------------------------
module wb_arbiter_grant
    import wb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   cyc0,
    input  logic   cyc1,
    output state_t state
);

    logic last_grant;
    logic tie_pick1;

    // Winner of a simultaneous request in IDLE
    always_comb begin
        tie_pick1 = 1'b0;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
        tie_pick1 = ~last_grant;
`else
        // last_grant is still tracked, but a tie always resolves to master 0
        tie_pick1 = last_grant & 1'b0;
`endif
    end

    // Grant FSM: grants are only taken from IDLE and held until cyc drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc0 && cyc1) begin
                        if (tie_pick1) begin
                            state      <= GRANT1;
                            last_grant <= 1'b1;
                        end else begin
                            state      <= GRANT0;
                            last_grant <= 1'b0;
                        end
                    end else if (cyc0) begin
                        state      <= GRANT0;
                        last_grant <= 1'b0;
                    end else if (cyc1) begin
                        state      <= GRANT1;
                        last_grant <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT0: begin
                    if (!cyc0) begin
                        state <= IDLE;
                    end else begin
                        state <= GRANT0;
                    end
                end
                GRANT1: begin
                    if (!cyc1) begin
                        state <= IDLE;
                    end else begin
                        state <= GRANT1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-master to one-slave pipelined Wishbone arbiter.
//   clk_i, rst_i          : clock and synchronous active-high reset
//   s0_wb_* / s1_wb_*     : master-side ports (cyc/stb/we/addr/data in,
//                           stall/ack/data out)
//   m_wb_*                : shared memory-side port
// The granted master is routed combinationally to m_wb_*; the other master
// sees stall=1, ack=0, data=0. Acks arriving while IDLE are dropped.
// Build option: WB_ARBITER_ROUND_ROBIN_EN (see wb_arbiter_grant).
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int G_ADDR_SIZE = C_ADDR_SIZE,
    parameter int G_DATA_SIZE = C_DATA_SIZE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s0_wb_cyc_i,
    input  logic                   s0_wb_stb_i,
    input  logic                   s0_wb_we_i,
    input  logic [G_ADDR_SIZE-1:0] s0_wb_addr_i,
    input  logic [G_DATA_SIZE-1:0] s0_wb_data_i,
    output logic                   s0_wb_stall_o,
    output logic                   s0_wb_ack_o,
    output logic [G_DATA_SIZE-1:0] s0_wb_data_o,
    input  logic                   s1_wb_cyc_i,
    input  logic                   s1_wb_stb_i,
    input  logic                   s1_wb_we_i,
    input  logic [G_ADDR_SIZE-1:0] s1_wb_addr_i,
    input  logic [G_DATA_SIZE-1:0] s1_wb_data_i,
    output logic                   s1_wb_stall_o,
    output logic                   s1_wb_ack_o,
    output logic [G_DATA_SIZE-1:0] s1_wb_data_o,
    output logic                   m_wb_cyc_o,
    output logic                   m_wb_stb_o,
    output logic                   m_wb_we_o,
    output logic [G_ADDR_SIZE-1:0] m_wb_addr_o,
    output logic [G_DATA_SIZE-1:0] m_wb_data_o,
    input  logic                   m_wb_stall_i,
    input  logic                   m_wb_ack_i,
    input  logic [G_DATA_SIZE-1:0] m_wb_data_i
);

    state_t state;
    state_t route_state;

    wb_arbiter_grant u_grant (
        .clk   (clk_i),
        .rst   (rst_i),
        .cyc0  (s0_wb_cyc_i),
        .cyc1  (s1_wb_cyc_i),
        .state (state)
    );

    // Force IDLE routing while reset is asserted so outputs are quiet from
    // the very first reset cycle, before the state register has been cleared
    always_comb begin
        route_state = IDLE;
        if (rst_i) begin
            route_state = IDLE;
        end else begin
            route_state = state;
        end
    end

    // Bus mux and response routing
    always_comb begin
        m_wb_cyc_o    = 1'b0;
        m_wb_stb_o    = 1'b0;
        m_wb_we_o     = 1'b0;
        m_wb_addr_o   = {G_ADDR_SIZE{1'b0}};
        m_wb_data_o   = {G_DATA_SIZE{1'b0}};
        s0_wb_stall_o = 1'b1;
        s0_wb_ack_o   = 1'b0;
        s0_wb_data_o  = {G_DATA_SIZE{1'b0}};
        s1_wb_stall_o = 1'b1;
        s1_wb_ack_o   = 1'b0;
        s1_wb_data_o  = {G_DATA_SIZE{1'b0}};
        case (route_state)
            GRANT0: begin
                m_wb_cyc_o    = s0_wb_cyc_i;
                m_wb_stb_o    = s0_wb_stb_i;
                m_wb_we_o     = s0_wb_we_i;
                m_wb_addr_o   = s0_wb_addr_i;
                m_wb_data_o   = s0_wb_data_i;
                s0_wb_stall_o = m_wb_stall_i;
                s0_wb_ack_o   = m_wb_ack_i;
                s0_wb_data_o  = m_wb_data_i;
            end
            GRANT1: begin
                m_wb_cyc_o    = s1_wb_cyc_i;
                m_wb_stb_o    = s1_wb_stb_i;
                m_wb_we_o     = s1_wb_we_i;
                m_wb_addr_o   = s1_wb_addr_i;
                m_wb_data_o   = s1_wb_data_i;
                s1_wb_stall_o = m_wb_stall_i;
                s1_wb_ack_o   = m_wb_ack_i;
                s1_wb_data_o  = m_wb_data_i;
            end
            IDLE: begin
                // defaults above: bus idle, both masters stalled, acks dropped
                m_wb_cyc_o = 1'b0;
            end
            default: begin
                m_wb_cyc_o = 1'b0;
            end
        endcase
    end

endmodule
